// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding control_unit.
// Holds the PC, runs a single-outstanding request/ack handshake to the
// instruction memory and latches the returned word into the instruction
// register. Optional fetch counter enabled by macro FETCH_CNT_EN.
module fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              en_pc_2,
  input  logic              branch_en,
  input  logic [9:0]        pc_offset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
`ifdef FETCH_CNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic [1:0]        fetch_state
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  // Branch target uses a sign-extended word offset turned into bytes;
  // everything wraps modulo 2^ADDR_W so negative targets fold below zero.
  function automatic logic [ADDR_W-1:0] calc_next_pc(
    input logic [ADDR_W-1:0] cur,
    input logic              br,
    input logic              inc2,
    input logic [9:0]        off
  );
    logic signed [ADDR_W-1:0] off_bytes;
    off_bytes = {{(ADDR_W-11){off[9]}}, off, 1'b0};
    if (br)
      calc_next_pc = cur + off_bytes;
    else if (inc2)
      calc_next_pc = cur + ADDR_W'(2);
    else
      calc_next_pc = cur;
  endfunction

  // Next-state logic for the fetch FSM, PC and instruction register
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_inc) begin
          pc_d    = calc_next_pc(pc_q, branch_en, en_pc_2, pc_offset);
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State registers; reset abandons any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request is decoded from state so an async reset drops it immediately
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign fetch_state = state_q;

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next count: one per accepted ack in S_REQ, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ && imem_ack)
      cnt_d = sat_inc16(cnt_q);
  end

  // Fetch counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'h0000;
    else     cnt_q <= cnt_d;
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of control_unit.
- Holds the program counter and drives a single-port instruction memory request/acknowledge interface.
- Latches the returned 16-bit word into an instruction register that feeds control_unit.instruction.
- Consumes control_unit's pc_inc, en_pc_2, branch_en and pc_offset to form the next PC.

Parameters:
ADDR_W, 16, width of the PC and instruction memory byte address
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
pc_inc  input  1  from control_unit: load next PC and start a new fetch
en_pc_2  input  1  from control_unit: next PC = PC + 2
branch_en  input  1  from control_unit: next PC = branch target
pc_offset  input  10  from control_unit: signed word offset for branch
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_W  instruction memory byte address
imem_ack  input  1  memory data valid this cycle
imem_rdata  input  16  memory read data
instruction  output  16  instruction register, to control_unit.instruction
inst_valid  output  1  instruction register holds the word for the current pc
pc  output  ADDR_W  current program counter
fetch_state  output  2  current FSM state encoding, for debug

Behaviour:
- Reset (async, rst=1) forces:
  - pc=RESET_PC, instruction=16'h0000, inst_valid=0, imem_req=0, imem_addr=RESET_PC.
  - State=S_BOOT.
  - Any outstanding request is abandoned; a late imem_ack is ignored.
- State encoding: S_BOOT=2'd0, S_REQ=2'd1, S_HOLD=2'd2. 2'd3 is illegal and recovers to S_BOOT on the next edge.
- S_BOOT:
  - One cycle after reset release with imem_req=0.
  - Next state: S_REQ.
- S_REQ:
  - imem_req=1 and imem_addr=pc, decoded from state. Both stay stable until imem_ack.
  - On an edge with imem_ack=1: instruction<=imem_rdata, inst_valid<=1, next state S_HOLD.
  - imem_ack in the first S_REQ cycle is legal (zero-wait memory).
  - pc_inc in S_REQ is ignored and pc is not changed.
- S_HOLD:
  - imem_req=0; instruction and inst_valid are held.
  - On an edge with pc_inc=1:
    - pc <= next_pc.
    - inst_valid <= 0.
    - next state S_REQ.
  - instruction keeps its old value until the new ack.
- next_pc priority:
  - branch_en=1: pc + ({{(ADDR_W-10){pc_offset[9]}},pc_offset} << 1).
  - else en_pc_2=1: pc + 2.
  - else: pc unchanged (refetch the same address).
- Arithmetic is modulo 2^ADDR_W:
  - pc=16'hFFFE with +2 wraps to 16'h0000.
  - Negative offsets wrap below 0.
- Offset range: -512..+511 words. Targets are always even.
- imem_ack outside S_REQ is ignored.
- Latency:
  - pc_inc sampled at edge N; imem_req high during cycle N..N+1.
  - With zero-wait memory, inst_valid=1 after edge N+1.
  - Each memory wait cycle adds one cycle.
- Reset asserted mid-request drops imem_req asynchronously in the same cycle.

Optional Feature:
- Macro FETCH_CNT_EN.
- When defined:
  - Adds output fetch_count [15:0], reset to 0.
  - Increments on each accepted imem_ack in S_REQ.
  - Saturates at 16'hFFFF.
- When undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

Test Plan:
1. Reset release, zero-wait memory returning 16'h1234 at address 0: imem_req high in the second cycle after release with imem_addr=0; instruction=16'h1234 and inst_valid=1 next edge; pc=0.
2. In S_HOLD at pc=16'h0010, pulse pc_inc with en_pc_2=1: pc=16'h0012, inst_valid=0, imem_addr=16'h0012; ack of 16'hABCD after 3 wait cycles gives instruction=16'hABCD and inst_valid=1.
3. Branches:
   - At pc=16'h0100, pc_inc with branch_en=1, en_pc_2=1, pc_offset=10'h3FC (-4): pc=16'h00F8 (branch priority).
   - Then pc_offset=10'h005: pc=16'h0102.
4. Wrap and refetch:
   - pc=16'hFFFE, pc_inc with en_pc_2=1: pc=16'h0000.
   - pc_inc with en_pc_2=0, branch_en=0: pc unchanged, new request to the same address.
5. Reset mid-request:
   - Assert rst while imem_req=1 and ack not yet given: imem_req=0 immediately, pc=RESET_PC, inst_valid=0.
   - A stray imem_ack during S_BOOT does not load instruction.
6. With FETCH_CNT_EN: 5 completed fetches give fetch_count=5; pc_inc pulses during S_REQ are ignored (pc unchanged, count unaffected).
